// File: rtl/scanner_pkg.sv
// Shared encodings for the buffered scanner: FSM states, command codes and a
// counter-width helper used to size internal counters from their maxima.
package scanner_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SCAN = 2'b01,
      FULL = 2'b10,
      XFER = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'b00,
      CMD_SCAN  = 2'b01,
      CMD_XFER  = 2'b10,
      CMD_ABORT = 2'b11
   } cmd_t;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scanner_buffered_if.sv
// Command, sensor and serial-output bundle of the buffered scanner.
// The master side issues commands and samples; the slave side is the scanner.
interface scanner_buffered_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) ();
   localparam int FILL_W = $clog2(DEPTH + 1);

   logic [1:0]        localTransferInput;
   logic              readyForTransferIn;
   logic [DATA_W-1:0] sampleIn;
   logic [1:0]        ps;
   logic [FILL_W-1:0] fillCount;
   logic              scanDone;
   logic              clkOut;
   logic              dataOut;
   logic [DATA_W-1:0] wordOut;

   modport master (
      output localTransferInput, readyForTransferIn, sampleIn,
      input  ps, fillCount, scanDone, clkOut, dataOut, wordOut
   );

   modport slave (
      input  localTransferInput, readyForTransferIn, sampleIn,
      output ps, fillCount, scanDone, clkOut, dataOut, wordOut
   );

endinterface

// File: rtl/scanner_sample_buffer.sv
// DEPTH x DATA_W sample store: synchronous write, combinational read.
// Contents are deliberately not reset; fill level lives in the controller.
module scanner_sample_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wrEn,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [DATA_W-1:0] wrData,
   input  logic [ADDR_W-1:0] rdAddr,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wrAddr] <= wrData;
      end
   end

   assign rdData = mem_q[rdAddr];

endmodule

// File: rtl/scanner_buffered.sv
// Buffered scanner: samples a parallel sensor into a word buffer, then shifts
// the buffer out MSB-first on a divided serial clock with ready-based pausing.
module scanner_buffered
   import scanner_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 16,
   parameter int SAMPLE_DIV = 4,
   parameter int CLK_DIV    = 2
) (
   input  logic clk,
   input  logic rst,
   scanner_buffered_if.slave bus
);

   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam int ADDR_W = cnt_w(DEPTH);
   localparam int BIT_W  = cnt_w(DATA_W);
   localparam int SAMP_W = cnt_w(SAMPLE_DIV);
   localparam int DIV_W  = cnt_w(CLK_DIV);

   localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(DATA_W - 1);
   localparam logic [SAMP_W-1:0] SAMP_MAX = SAMP_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

   state_t            ps_q, ps_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [SAMP_W-1:0] samp_q, samp_d;
   logic [BIT_W-1:0]  bit_q, bit_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              clk_out_q, clk_out_d;
   logic              data_out_q, data_out_d;
   logic [DATA_W-1:0] word_out_q, word_out_d;
   logic              scan_done_q, scan_done_d;

   cmd_t              cmd;
   logic              start_xfer;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   // Outside XFER the read port points at word 0 so a transfer can start at once;
   // inside XFER it pre-fetches the word that follows the one in flight.
   assign rd_addr = (ps_q == XFER) ? word_q + 1'b1 : '0;
   assign wr_addr = fill_q[ADDR_W-1:0];

   scanner_sample_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk    (clk),
      .wrEn   (wr_en),
      .wrAddr (wr_addr),
      .wrData (bus.sampleIn),
      .rdAddr (rd_addr),
      .rdData (rd_data)
   );

   always_comb begin
      ps_d        = ps_q;
      fill_d      = fill_q;
      samp_d      = samp_q;
      bit_d       = bit_q;
      word_d      = word_q;
      div_d       = div_q;
      clk_out_d   = clk_out_q;
      data_out_d  = data_out_q;
      word_out_d  = word_out_q;
      wr_en       = 1'b0;
      start_xfer  = 1'b0;
      cmd         = cmd_t'(bus.localTransferInput);

      case (ps_q)
         IDLE: begin
            if (cmd == CMD_ABORT) begin
               fill_d = '0;
            end else if (cmd == CMD_SCAN) begin
               ps_d   = SCAN;
               fill_d = '0;
               samp_d = '0;
            end else if (cmd == CMD_XFER && fill_q != '0 && bus.readyForTransferIn) begin
               start_xfer = 1'b1;
            end
         end
         SCAN: begin
            if (cmd == CMD_ABORT) begin
               ps_d   = IDLE;
               fill_d = '0;
            end else if (cmd == CMD_SCAN) begin
               fill_d = '0;
               samp_d = '0;
            end else if (cmd == CMD_XFER && fill_q != '0 && bus.readyForTransferIn) begin
               start_xfer = 1'b1;
            end else if (samp_q == SAMP_MAX) begin
               samp_d = '0;
               wr_en  = 1'b1;
               fill_d = fill_q + 1'b1;
               if (fill_q + 1'b1 == FILL_MAX) begin
                  ps_d = FULL;
               end
            end else begin
               samp_d = samp_q + 1'b1;
            end
         end
         FULL: begin
            if (cmd == CMD_ABORT) begin
               ps_d = IDLE;
            end else if (cmd == CMD_SCAN) begin
               ps_d   = SCAN;
               fill_d = '0;
               samp_d = '0;
            end else if (cmd == CMD_XFER && bus.readyForTransferIn) begin
               start_xfer = 1'b1;
            end
         end
         XFER: begin
            if (cmd == CMD_ABORT) begin
               ps_d       = IDLE;
               fill_d     = '0;
               word_d     = '0;
               bit_d      = '0;
               div_d      = '0;
               clk_out_d  = 1'b0;
               data_out_d = 1'b0;
               word_out_d = '0;
            end else if (!clk_out_q) begin
               // Pausing is only allowed before the first bit of a word starts.
               if (bit_q == BIT_MSB && div_q == '0 && !bus.readyForTransferIn) begin
                  div_d = '0;
               end else if (div_q == DIV_MAX) begin
                  div_d     = '0;
                  clk_out_d = 1'b1;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end else if (div_q != DIV_MAX) begin
               div_d = div_q + 1'b1;
            end else begin
               div_d     = '0;
               clk_out_d = 1'b0;
               if (bit_q != '0) begin
                  bit_d      = bit_q - 1'b1;
                  data_out_d = word_out_q[bit_q - 1'b1];
               end else if (FILL_W'(word_q) + 1'b1 == fill_q) begin
                  ps_d       = IDLE;
                  fill_d     = '0;
                  word_d     = '0;
                  data_out_d = 1'b0;
                  word_out_d = '0;
               end else begin
                  word_d     = word_q + 1'b1;
                  bit_d      = BIT_MSB;
                  data_out_d = rd_data[DATA_W-1];
                  word_out_d = rd_data;
               end
            end
         end
         default: begin
            ps_d = IDLE;
         end
      endcase

      if (start_xfer) begin
         ps_d       = XFER;
         word_d     = '0;
         bit_d      = BIT_MSB;
         div_d      = '0;
         clk_out_d  = 1'b0;
         data_out_d = rd_data[DATA_W-1];
         word_out_d = rd_data;
      end

      scan_done_d = (ps_d == FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_q        <= IDLE;
         fill_q      <= '0;
         samp_q      <= '0;
         bit_q       <= '0;
         word_q      <= '0;
         div_q       <= '0;
         clk_out_q   <= 1'b0;
         data_out_q  <= 1'b0;
         word_out_q  <= '0;
         scan_done_q <= 1'b0;
      end else begin
         ps_q        <= ps_d;
         fill_q      <= fill_d;
         samp_q      <= samp_d;
         bit_q       <= bit_d;
         word_q      <= word_d;
         div_q       <= div_d;
         clk_out_q   <= clk_out_d;
         data_out_q  <= data_out_d;
         word_out_q  <= word_out_d;
         scan_done_q <= scan_done_d;
      end
   end

   assign bus.ps        = ps_q;
   assign bus.fillCount = fill_q;
   assign bus.scanDone  = scan_done_q;
   assign bus.clkOut    = clk_out_q;
   assign bus.dataOut   = data_out_q;
   assign bus.wordOut   = word_out_q;

endmodule

// File: tb/tb_scanner_buffered.sv
// Randomised bench for scanner_buffered: a rule-level model predicts buffer
// contents and transfer timing; a monitor reassembles serial words and scores them.
module tb_scanner_buffered;

   localparam int DATA_W     = 8;
   localparam int DEPTH      = 4;
   localparam int SAMPLE_DIV = 2;
   localparam int CLK_DIV    = 2;
   localparam int BIT_CYC    = 2 * CLK_DIV;

   logic clk;
   logic rst;

   scanner_buffered_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   scanner_buffered #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .SAMPLE_DIV (SAMPLE_DIV),
      .CLK_DIV    (CLK_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int flush_gen = 0;
   int words_rx = 0;

   logic [DATA_W-1:0] model_buf [$];
   logic [DATA_W-1:0] exp_q [$];

   int                mon_seen = 0;
   int                mon_bits = 0;
   logic              mon_prev = 1'b0;
   logic              mon_held = 1'b0;
   logic [DATA_W-1:0] mon_sh = '0;
   logic [DATA_W-1:0] mon_wo = '0;
   logic [DATA_W-1:0] mon_exp = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_ps"}, 32'(bus.ps), 0);
      chk({tag, "_fill"}, 32'(bus.fillCount), 0);
      chk({tag, "_done"}, 32'(bus.scanDone), 0);
      chk({tag, "_clk"}, 32'(bus.clkOut), 0);
      chk({tag, "_data"}, 32'(bus.dataOut), 0);
      chk({tag, "_word"}, 32'(bus.wordOut), 0);
   endtask

   // Serial monitor: a word is the DATA_W bits seen on clkOut rising edges.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_seen != flush_gen) begin
            mon_seen = flush_gen;
            mon_bits = 0;
            mon_prev = 1'b0;
            exp_q.delete();
         end
         if (bus.clkOut && !mon_prev) begin
            mon_held = bus.dataOut;
            mon_sh   = {mon_sh[DATA_W-2:0], bus.dataOut};
            if (mon_bits == 0) mon_wo = bus.wordOut;
            mon_bits++;
            if (mon_bits == DATA_W) begin
               mon_bits = 0;
               words_rx++;
               chk("pending_words", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  mon_exp = exp_q.pop_front();
                  chk("serial_word", 32'(mon_sh), 32'(mon_exp));
                  chk("word_out", 32'(mon_wo), 32'(mon_exp));
               end
            end
         end else if (bus.clkOut && mon_prev) begin
            chk("data_stable_high", 32'(bus.dataOut), 32'(mon_held));
         end
         mon_prev = bus.clkOut;
      end
   end

   // Enter SCAN, then run n cycles; every SAMPLE_DIV-th cycle captures a sample.
   task automatic scan_run(input int n, input bit seq);
      logic [DATA_W-1:0] s;
      bus.localTransferInput = 2'b01;
      tick();
      bus.localTransferInput = 2'b00;
      model_buf.delete();
      chk("scan_entry_ps", 32'(bus.ps), 1);
      chk("scan_entry_fill", 32'(bus.fillCount), 0);
      for (int k = 1; k <= n; k++) begin
         s = seq ? DATA_W'(8'hA0 + k) : DATA_W'($urandom);
         bus.sampleIn = s;
         tick();
         if (k % SAMPLE_DIV == 0 && model_buf.size() < DEPTH) model_buf.push_back(s);
         chk("scan_fill", 32'(bus.fillCount), 32'(model_buf.size()));
         chk("scan_ps", 32'(bus.ps), (model_buf.size() == DEPTH) ? 2 : 1);
         chk("scan_done", 32'(bus.scanDone), 32'(model_buf.size() == DEPTH));
      end
   endtask

   // Full transfer; optionally drop ready for drop_len cycles after word drop_word.
   task automatic do_xfer(input int drop_word, input int drop_len);
      int  n;
      int  rem;
      int  base;
      int  w0;
      int  limit;
      bit  dropped;
      base    = model_buf.size() * DATA_W * BIT_CYC;
      limit   = base + drop_len + 20;
      n       = 0;
      rem     = 0;
      dropped = 1'b0;
      w0      = words_rx;
      foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
      bus.readyForTransferIn = 1'b1;
      bus.localTransferInput = 2'b10;
      tick();
      bus.localTransferInput = 2'b00;
      chk("xfer_entry_ps", 32'(bus.ps), 3);
      while (n < limit) begin
         tick();
         n++;
         if (rem > 0) begin
            chk("pause_clk_low", 32'(bus.clkOut), 0);
            rem--;
            if (rem == 0) bus.readyForTransferIn = 1'b1;
         end
         if (bus.ps == 2'b00) break;
         if (!dropped && drop_word >= 0 && words_rx - w0 == drop_word + 1 && !bus.clkOut) begin
            bus.readyForTransferIn = 1'b0;
            rem     = drop_len;
            dropped = 1'b1;
         end
      end
      bus.readyForTransferIn = 1'b1;
      chk("xfer_cycles", 32'(n), 32'(base + (dropped ? drop_len : 0)));
      chk("xfer_words_rx", 32'(words_rx - w0), 32'(model_buf.size()));
      chk("xfer_left_in_queue", 32'(exp_q.size()), 0);
      chk_quiet("xfer_end");
      model_buf.delete();
   endtask

   // Start a transfer and wait until clkOut is high somewhere past min_wait cycles.
   task automatic xfer_to_mid_bit(input int min_wait);
      int t;
      foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
      bus.readyForTransferIn = 1'b1;
      bus.localTransferInput = 2'b10;
      tick();
      bus.localTransferInput = 2'b00;
      for (int i = 0; i < min_wait; i++) tick();
      t = 0;
      while (!bus.clkOut && t < 3 * BIT_CYC) begin
         tick();
         t++;
      end
      chk("mid_bit_reached", 32'(bus.clkOut), 1);
   endtask

   initial begin
      int len;
      int dw;

      rst = 1'b0;
      bus.localTransferInput = 2'b00;
      bus.readyForTransferIn = 1'b0;
      bus.sampleIn = '0;
      #12;
      chk_quiet("in_reset");
      rst = 1'b1;

      // Idle with NOP
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_quiet("idle");
      end

      // Sequential-pattern scan to FULL, then hold
      scan_run(8 + 20, 1'b1);

      // Transfer from FULL with no pauses
      do_xfer(-1, 0);

      // Transfer with ready dropped after word 1
      scan_run(8, 1'b0);
      do_xfer(1, $urandom_range(5, 20));

      // Restart from FULL, abort during SCAN at fillCount=2
      scan_run(8, 1'b0);
      scan_run(2 * SAMPLE_DIV, 1'b0);
      chk("pre_abort_fill", 32'(bus.fillCount), 2);
      bus.localTransferInput = 2'b11;
      tick();
      bus.localTransferInput = 2'b00;
      chk("scan_abort_ps", 32'(bus.ps), 0);
      chk("scan_abort_fill", 32'(bus.fillCount), 0);
      model_buf.delete();

      // Abort mid-bit during XFER
      scan_run(8, 1'b0);
      xfer_to_mid_bit($urandom_range(3, 60));
      bus.localTransferInput = 2'b11;
      tick();
      bus.localTransferInput = 2'b00;
      flush_gen++;
      chk_quiet("xfer_abort");
      model_buf.delete();
      tick();

      // Randomised partial/full scans followed by transfers with random pauses
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(SAMPLE_DIV, 12);
         scan_run(len, 1'b0);
         dw = (model_buf.size() > 1) ? int'($urandom_range(0, model_buf.size() - 2)) : -1;
         do_xfer(dw, $urandom_range(1, 8));
      end

      // Asynchronous reset between clock edges during XFER
      scan_run(8, 1'b0);
      xfer_to_mid_bit($urandom_range(3, 60));
      #3;
      rst = 1'b0;
      #1;
      chk_quiet("async_reset");
      flush_gen++;
      #2;
      rst = 1'b1;
      model_buf.delete();

      // Transfer request with an empty buffer is ignored
      bus.readyForTransferIn = 1'b1;
      bus.localTransferInput = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_quiet("empty_xfer");
      end
      bus.localTransferInput = 2'b00;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scanner_buffered.md
Name: scanner_buffered

Overview:
- Parametrised successor to the 2-bit-state scanner.
- Captures samples from a parallel sensor port into an internal buffer of configurable width and depth at a programmable sample rate.
- On command, and while downstream is ready, it shifts the whole buffer out MSB-first on a divided serial clock (clkOut/dataOut).
- Adds abort and rescan commands, pause on loss of downstream ready, and fill-level reporting.

Parameters:
DATA_W, 8, bits per sample word
DEPTH, 16, buffer depth in words (>=2)
SAMPLE_DIV, 4, clk cycles between samples while scanning (>=1)
CLK_DIV, 2, clk cycles per clkOut half-period (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
localTransferInput  in  2  command: 00 nop, 01 scan, 10 transfer, 11 abort
readyForTransferIn  in  1  downstream ready for serial data
sampleIn  in  DATA_W  sensor sample, valid every cycle
ps  out  2  present state: 00 IDLE, 01 SCAN, 10 FULL, 11 XFER
fillCount  out  $clog2(DEPTH+1)  words currently held
scanDone  out  1  high while in FULL
clkOut  out  1  serial clock
dataOut  out  1  serial data, stable while clkOut high
wordOut  out  DATA_W  word currently being serialised (0 outside XFER)

Behaviour:
- Reset (rst=0, async): ps=IDLE, fillCount=0, scanDone=0, clkOut=0, dataOut=0, wordOut=0; all counters cleared. Mid-operation reset aborts immediately with no partial output.
- Commands are sampled every cycle. Abort (11) has priority over all others in every state.
- IDLE:
  - 01 -> SCAN next cycle; fillCount cleared.
  - 10 with fillCount>0 and readyForTransferIn=1 -> XFER.
  - 10 with fillCount=0 is ignored.
  - 11 clears fillCount.
- SCAN:
  - Sample counter starts at 0 on entry. sampleIn is written at buffer[fillCount] on the SAMPLE_DIV-th cycle after entry, then every SAMPLE_DIV cycles.
  - fillCount increments in the same edge as the write.
  - The write that makes fillCount=DEPTH moves ps to FULL on the same edge.
  - 01 restarts the scan (fillCount=0, counter=0).
  - 10 -> XFER if readyForTransferIn=1, sending the partial buffer.
  - 11 -> IDLE, fillCount=0.
- FULL:
  - Holds the buffer; scanDone=1; no further writes (no overwrite/wrap).
  - 10 with readyForTransferIn=1 -> XFER.
  - 01 -> SCAN (buffer cleared).
  - 11 -> IDLE.
- XFER:
  - Sends words 0..fillCount-1 in order, MSB first.
  - Each bit:
    - dataOut is driven with clkOut=0 for CLK_DIV cycles.
    - clkOut=1 for CLK_DIV cycles.
    - The bit period is 2*CLK_DIV cycles.
  - wordOut shows the word in flight.
  - If readyForTransferIn=0 at a word boundary (before bit DATA_W-1 of the next word), clkOut is held 0 and the bit index is held until ready returns. A bit in progress always completes.
  - After the last bit's high phase: clkOut=0, dataOut=0, fillCount=0, ps -> IDLE.
  - Total cycles = fillCount*DATA_W*2*CLK_DIV, with no pauses.
  - 11 -> IDLE next edge, clkOut forced 0, buffer discarded.
  - 01 and 10 are ignored.
- Widths:
  - fillCount saturates at DEPTH.
  - Internal counters are sized $clog2 of their maxima; none wraps silently.

Decomposition:
- Package scanner_pkg:
  - state encodings IDLE/SCAN/FULL/XFER
  - command codes CMD_NOP/CMD_SCAN/CMD_XFER/CMD_ABORT
- Sub-module scanner_sample_buffer:
  - DEPTH x DATA_W register array
  - synchronous write port (wrEn, wrAddr, wrData)
  - combinational read port (rdAddr)
  - no reset on contents
- Top module holds the FSM, sample divider, bit/word counters and clkOut divider.

Test Plan (DATA_W=8, DEPTH=4, SAMPLE_DIV=2, CLK_DIV=2):
1. Reset then idle 4 cycles with cmd 00 -> ps=00, fillCount=0, clkOut=0, dataOut=0 throughout.
2. cmd 01, sampleIn=8'hA0+cycle count:
   - writes at cycles 2,4,6,8 after SCAN entry.
   - fillCount steps 1..4.
   - ps=10 and scanDone=1 on the 4th write edge.
   - Hold 20 cycles -> no change.
3. From FULL, ready=1, cmd 10:
   - 4 words x 8 bits, each bit 2 cycles low and 2 high, 128 cycles total.
   - Captured bits on clkOut rising edges equal the stored words MSB-first.
   - Then ps=00, fillCount=0.
4. XFER with ready dropped after word 1:
   - clkOut stays 0 for the full drop duration.
   - Resumes with word 2, bit 7.
   - No bits lost or duplicated.
5. Abort:
   - cmd 11 during SCAN (fillCount=2) -> IDLE, fillCount=0.
   - cmd 11 mid-bit in XFER -> clkOut=0 next edge, ps=00.
6. Async reset:
   - rst=0 asserted between clock edges during XFER -> all outputs reset immediately, without waiting for clk.
   - After rst=1, cmd 10 with fillCount=0 -> ignored, stays IDLE.
